// File: rtl/bist_ctrl.sv
// bist_ctrl: stimulus generator plus MISR response compactor with golden-signature check.
// Stimulus is a binary counter by default; define BIST_LFSR_EN for a Galois LFSR source.
module bist_ctrl #(
  parameter int StimWidth = 8,
  parameter int RespWidth = 8,
  parameter int NumPatterns = 256,
  parameter int RespLatency = 0,
  parameter logic [RespWidth-1:0] MisrPoly = RespWidth'(8'h1D)
`ifdef BIST_LFSR_EN
  ,
  parameter logic [StimWidth-1:0] StimPoly = StimWidth'(8'h1D),
  parameter logic [StimWidth-1:0] LfsrSeed = StimWidth'(8'h01)
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [RespWidth-1:0] golden_i,
  input  logic [RespWidth-1:0] resp_i,
  output logic [StimWidth-1:0] stim_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [RespWidth-1:0] signature_o
);
  localparam int CW = $clog2(NumPatterns + RespLatency + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic                 r_start, r_pass, w_busy, w_enter, w_cmp;
  logic [CW-1:0]        r_cnt;
  logic [StimWidth-1:0] r_stim, w_step, w_first;
  logic [RespWidth-1:0] r_sig, w_sig_nxt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  // start is registered once, so pattern 0 appears one cycle after the accepting edge
  always_comb begin
    w_enter = r_start && (r_state == IDLE || r_state == DONE);
    w_next = r_state;
    if (w_enter) w_next = RUN;
    else if (r_state == RUN && r_cnt == CW'(NumPatterns - 1)) w_next = (RespLatency > 0) ? FLUSH : DONE;
    else if (r_state == FLUSH && r_cnt == CW'(NumPatterns + RespLatency - 1)) w_next = DONE;
  end
  assign w_busy = r_state == RUN || r_state == FLUSH;
`ifdef BIST_LFSR_EN
  assign w_step  = {r_stim[StimWidth-2:0], 1'b0} ^ (r_stim[StimWidth-1] ? StimPoly : '0);
  assign w_first = LfsrSeed;
`else
  assign w_step  = r_stim + StimWidth'(1);
  assign w_first = '0;
`endif
  assign w_sig_nxt = {r_sig[RespWidth-2:0], 1'b0} ^ (r_sig[RespWidth-1] ? MisrPoly : '0) ^ resp_i;
  // responses lag stimulus by RespLatency, so only the last NumPatterns busy cycles compact
  generate
    if (RespLatency == 0) begin : g_nolat
      assign w_cmp = w_busy;
    end else begin : g_lat
      assign w_cmp = w_busy && (r_cnt >= CW'(RespLatency));
    end
  endgenerate
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_start <= 1'b0;
      r_cnt   <= '0;
      r_stim  <= '0;
      r_sig   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_start <= start_i && (r_state == IDLE || r_state == DONE);
      r_cnt   <= w_enter ? '0 : w_busy ? r_cnt + CW'(1) : r_cnt;
      r_stim  <= (w_next != RUN) ? '0 : (r_state == RUN) ? w_step : w_first;
      r_sig   <= w_enter ? '0 : w_cmp ? w_sig_nxt : r_sig;
      r_pass  <= w_enter ? 1'b0 : (w_busy && w_next == DONE) ? (w_sig_nxt == golden_i) : r_pass;
    end
  assign stim_o      = r_stim;
  assign busy_o      = w_busy;
  assign done_o      = r_state == DONE;
  assign pass_o      = r_pass;
  assign signature_o = r_sig;
endmodule
